traffic_generator_gmii_burst_scheduler: RTL and testbench

Sequences frame transmission for the GMII traffic generator.
- Decides when the frame engine starts each frame.
- Enforces inter-frame and inter-burst gaps, and frames-per-burst grouping.
- Applies the total-frame limit and the start/stop control.
- Sits between the AXI-Lite register file (config inputs) and the GMII frame/serialiser engine (start/done handshake).
- Issues the per-frame sequence number that the engine inserts in dynamic mode.

---
 rtl/traffic_generator_gmii_pkg.sv | 18 +
 rtl/traffic_generator_gmii_gap_counter.sv | 28 ++
 rtl/traffic_generator_gmii_burst_scheduler.sv | 167 ++++++++++++++++
 tb/tb_traffic_generator_gmii_burst_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_generator_gmii_pkg.sv
// Shared types and constants for the GMII traffic generator burst scheduler.
package traffic_generator_gmii_pkg;

    localparam int unsigned MIN_GAP     = 12;
    localparam int unsigned BURST_W     = 32;
    localparam int unsigned CTRL_W      = 2;
    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_LIMIT  = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DONE,
        GAP,
        STOP
    } sched_state_t;

endpackage

// File: rtl/traffic_generator_gmii_gap_counter.sv
// Loadable down-counter timing IFG/IBG; expire_c flags the decrement that lands on zero.
module traffic_generator_gmii_gap_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expire_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // Expiring on the final decrement keeps done->start spacing at G+1 cycles.
    assign expire_c = dec && (count <= W'(1));

endmodule

// File: rtl/traffic_generator_gmii_burst_scheduler.sv
// Frame start scheduler: gaps, burst grouping, frame limit and run control.
// Define TG_BURST_SCHED_STATS_EN to enable the bursts_sent counter.
module traffic_generator_gmii_burst_scheduler #(
    parameter int unsigned CNT_W   = 64,
    parameter int unsigned GAP_W   = 32,
    parameter int unsigned MIN_GAP = traffic_generator_gmii_pkg::MIN_GAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_enable,
    input  logic             ctrl_limit,
    input  logic [GAP_W-1:0] cfg_ifg,
    input  logic [31:0]      cfg_frames_per_burst,
    input  logic [GAP_W-1:0] cfg_ibg,
    input  logic [CNT_W-1:0] cfg_total_frames,
    output logic             tx_start,
    output logic [CNT_W-1:0] tx_seq,
    input  logic             tx_done,
    output logic [CNT_W-1:0] frames_sent,
    output logic             busy,
    output logic             run_done,
    output logic [31:0]      bursts_sent
);

    import traffic_generator_gmii_pkg::*;

    sched_state_t       state;
    logic [CTRL_W-1:0]  ctrl;
    logic [GAP_W-1:0]   ifg_lat;
    logic [GAP_W-1:0]   ibg_lat;
    logic [BURST_W-1:0] fpb_lat;
    logic [CNT_W-1:0]   total_lat;
    logic [CNT_W-1:0]   seq_cnt;
    logic [BURST_W-1:0] burst_idx;

    logic [BURST_W-1:0] fpb_eff_c;
    logic [BURST_W-1:0] burst_idx_inc_c;
    logic               burst_end_c;
    logic [GAP_W-1:0]   gap_sel_c;
    logic [GAP_W-1:0]   gap_eff_c;
    logic [GAP_W-1:0]   gap_load_val_c;
    logic               gap_load_c;
    logic               gap_dec_c;
    logic               gap_expire_c;
    logic               limit_hit_c;

    assign ctrl[CTRL_ENABLE] = ctrl_enable;
    assign ctrl[CTRL_LIMIT]  = ctrl_limit;

    // Gap selection: IBG replaces IFG on the last frame of a burst, clamped to MIN_GAP.
    assign fpb_eff_c       = (fpb_lat == '0) ? BURST_W'(1) : fpb_lat;
    assign burst_idx_inc_c = burst_idx + BURST_W'(1);
    assign burst_end_c     = (burst_idx_inc_c >= fpb_eff_c);
    assign gap_sel_c       = burst_end_c ? ibg_lat : ifg_lat;
    assign gap_eff_c       = (gap_sel_c < GAP_W'(MIN_GAP)) ? GAP_W'(MIN_GAP) : gap_sel_c;
    assign gap_load_val_c  = gap_eff_c - GAP_W'(1);
    assign gap_load_c      = (state == WAIT_DONE) && tx_done;
    assign gap_dec_c       = (state == GAP);
    assign limit_hit_c     = ctrl[CTRL_LIMIT] && (frames_sent >= total_lat);

    traffic_generator_gmii_gap_counter #(
        .W (GAP_W)
    ) u_gap_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load_c),
        .load_val (gap_load_val_c),
        .dec      (gap_dec_c),
        .expire_c (gap_expire_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            tx_seq      <= '0;
            seq_cnt     <= '0;
            frames_sent <= '0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            burst_idx   <= '0;
            ifg_lat     <= '0;
            ibg_lat     <= '0;
            fpb_lat     <= '0;
            total_lat   <= '0;
`ifdef TG_BURST_SCHED_STATS_EN
            bursts_sent <= '0;
`endif
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl[CTRL_ENABLE]) begin
                        state       <= START;
                        busy        <= 1'b1;
                        run_done    <= 1'b0;
                        frames_sent <= '0;
                        tx_seq      <= '0;
                        seq_cnt     <= '0;
                        burst_idx   <= '0;
                        ifg_lat     <= cfg_ifg;
                        ibg_lat     <= cfg_ibg;
                        fpb_lat     <= cfg_frames_per_burst;
                        total_lat   <= cfg_total_frames;
`ifdef TG_BURST_SCHED_STATS_EN
                        bursts_sent <= '0;
`endif
                    end
                end
                START: begin
                    if (limit_hit_c) begin
                        state    <= STOP;
                        busy     <= 1'b0;
                        run_done <= 1'b1;
`ifdef TG_BURST_SCHED_STATS_EN
                        // A partially filled burst still counts once the run ends.
                        if (burst_idx != '0) begin
                            bursts_sent <= bursts_sent + 32'(1);
                        end
`endif
                    end else begin
                        state    <= WAIT_DONE;
                        tx_start <= 1'b1;
                        tx_seq   <= seq_cnt;
                        seq_cnt  <= seq_cnt + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        state       <= GAP;
                        frames_sent <= frames_sent + CNT_W'(1);
                        burst_idx   <= burst_end_c ? '0 : burst_idx_inc_c;
`ifdef TG_BURST_SCHED_STATS_EN
                        if (burst_end_c) begin
                            bursts_sent <= bursts_sent + 32'(1);
                        end
`endif
                    end
                end
                GAP: begin
                    if (gap_expire_c) begin
                        if (ctrl[CTRL_ENABLE]) begin
                            state <= START;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                STOP: begin
                    if (!ctrl[CTRL_ENABLE]) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef TG_BURST_SCHED_STATS_EN
    assign bursts_sent = '0;
`endif

endmodule

// File: tb/tb_traffic_generator_gmii_burst_scheduler.sv
// Directed bench for the burst scheduler with a fixed-latency frame engine model.
module tb_traffic_generator_gmii_burst_scheduler;

    localparam int DONE_LAT = 64;
`ifdef TG_BURST_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_enable;
    logic        ctrl_limit;
    logic [31:0] cfg_ifg;
    logic [31:0] cfg_frames_per_burst;
    logic [31:0] cfg_ibg;
    logic [63:0] cfg_total_frames;
    logic        tx_start;
    logic [63:0] tx_seq;
    logic        tx_done;
    logic [63:0] frames_sent;
    logic        busy;
    logic        run_done;
    logic [31:0] bursts_sent;

    logic eng_done;
    logic inj_done;
    int   eng_cnt;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    int st_cyc[$];
    int st_seq[$];
    int done_cyc[$];

    assign tx_done = eng_done | inj_done;

    traffic_generator_gmii_burst_scheduler dut (
        .clk                  (clk),
        .rst                  (rst),
        .ctrl_enable          (ctrl_enable),
        .ctrl_limit           (ctrl_limit),
        .cfg_ifg              (cfg_ifg),
        .cfg_frames_per_burst (cfg_frames_per_burst),
        .cfg_ibg              (cfg_ibg),
        .cfg_total_frames     (cfg_total_frames),
        .tx_start             (tx_start),
        .tx_seq               (tx_seq),
        .tx_done              (tx_done),
        .frames_sent          (frames_sent),
        .busy                 (busy),
        .run_done             (run_done),
        .bursts_sent          (bursts_sent)
    );

    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame engine: tx_done pulses DONE_LAT cycles after the tx_start cycle.
    initial begin
        eng_done = 1'b0;
        eng_cnt  = 0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (rst) begin
                eng_cnt = 0;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done = 1'b1;
                    done_cyc.push_back(cyc);
                end
            end else if (tx_start) begin
                eng_cnt = DONE_LAT;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                st_cyc.push_back(cyc);
                st_seq.push_back(int'(tx_seq));
            end
        end
    end

    typedef struct {
        logic [31:0] ifg;
        logic [31:0] fpb;
        logic [31:0] ibg;
        logic [63:0] total;
        int          exp_starts;
        int          sp_ifg;
        int          sp_ibg;
        int          exp_bursts;
        int          budget;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        st_cyc.delete();
        st_seq.delete();
        done_cyc.delete();
    endtask

    task automatic wait_run_done(input int budget, input string name);
        int lat;
        @(negedge clk);
        lat = 1;
        while (run_done !== 1'b1 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        check(name, 64'(run_done), 64'd1);
    endtask

    task automatic wait_starts(input int n, input int budget, input string name);
        int k = 0;
        while (st_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(st_cyc.size() >= n), 64'd1);
    endtask

    task automatic wait_dones(input int n, input int budget, input string name);
        int k = 0;
        while (done_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(done_cyc.size() >= n), 64'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    task automatic check_spacing(input string tag, input int n, input int exp_sp);
        for (int i = 0; i + 1 < n && i + 1 < st_cyc.size() && i < done_cyc.size(); i++)
            check($sformatf("%s_spacing_%0d", tag, i), 64'(st_cyc[i+1] - done_cyc[i]), 64'(exp_sp));
    endtask

    initial begin
        int en_cyc;
        int fpb_eff;
        int exp_sp;

        vecs[0] = '{32'd20, 32'd2, 32'd84, 64'd10, 10, 21, 85, 5, 5000};
        vecs[1] = '{32'd20, 32'd2, 32'd84, 64'd0,  0,  21, 85, 0, 3};
        vecs[2] = '{32'd4,  32'd1, 32'd4,  64'd4,  4,  13, 13, 4, 2000};
        vecs[3] = '{32'd30, 32'd0, 32'd50, 64'd3,  3,  31, 51, 3, 2000};
        vecs[4] = '{32'd15, 32'd3, 32'd40, 64'd4,  4,  16, 41, 2, 2000};
        vecs[5] = '{32'd11, 32'd2, 32'd13, 64'd4,  4,  13, 14, 2, 2000};

        rst                  = 1'b1;
        inj_done             = 1'b0;
        ctrl_enable          = 1'b0;
        ctrl_limit           = 1'b0;
        cfg_ifg              = '0;
        cfg_frames_per_burst = '0;
        cfg_ibg              = '0;
        cfg_total_frames     = '0;
        repeat (3) @(negedge clk);
        check("reset_tx_start", 64'(tx_start), 64'd0);
        check("reset_tx_seq", tx_seq, 64'd0);
        check("reset_frames_sent", frames_sent, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_run_done", 64'(run_done), 64'd0);
        check("reset_bursts_sent", 64'(bursts_sent), 64'd0);
        rst = 1'b0;

        // Limited runs from the vector table.
        for (int v = 0; v < 6; v++) begin
            ctrl_enable = 1'b0;
            repeat (3) @(negedge clk);
            clear_log();
            cfg_ifg              = vecs[v].ifg;
            cfg_frames_per_burst = vecs[v].fpb;
            cfg_ibg              = vecs[v].ibg;
            cfg_total_frames     = vecs[v].total;
            ctrl_limit           = 1'b1;
            ctrl_enable          = 1'b1;
            wait_run_done(vecs[v].budget, $sformatf("v%0d_run_done", v));
            repeat (5) @(negedge clk);
            check($sformatf("v%0d_start_count", v), 64'(st_cyc.size()), 64'(vecs[v].exp_starts));
            for (int i = 0; i < st_seq.size(); i++)
                check($sformatf("v%0d_seq_%0d", v, i), 64'(st_seq[i]), 64'(i));
            fpb_eff = (vecs[v].fpb == 0) ? 1 : int'(vecs[v].fpb);
            for (int i = 0; i + 1 < st_cyc.size() && i < done_cyc.size(); i++) begin
                exp_sp = (((i + 1) % fpb_eff) == 0) ? vecs[v].sp_ibg : vecs[v].sp_ifg;
                check($sformatf("v%0d_spacing_%0d", v, i), 64'(st_cyc[i+1] - done_cyc[i]), 64'(exp_sp));
            end
            check($sformatf("v%0d_frames_sent", v), frames_sent, vecs[v].total);
            check($sformatf("v%0d_busy", v), 64'(busy), 64'd0);
            check($sformatf("v%0d_bursts_sent", v), 64'(bursts_sent), STATS ? 64'(vecs[v].exp_bursts) : 64'd0);
        end

        // Unlimited run with MIN_GAP clamp; enable dropped mid-frame.
        ctrl_enable = 1'b0;
        repeat (3) @(negedge clk);
        clear_log();
        cfg_ifg = 32'd4; cfg_frames_per_burst = 32'd1; cfg_ibg = 32'd4; cfg_total_frames = 64'd2;
        ctrl_limit  = 1'b0;
        ctrl_enable = 1'b1;
        wait_starts(3, 1000, "unl_third_start");
        repeat (10) @(negedge clk);
        ctrl_enable = 1'b0;
        wait_idle(500, "unl_idle");
        check("unl_frames_sent", frames_sent, 64'd3);
        check("unl_run_done", 64'(run_done), 64'd0);
        check("unl_bursts_sent", 64'(bursts_sent), STATS ? 64'd3 : 64'd0);
        check_spacing("unl", 3, 13);
        repeat (50) @(negedge clk);
        check("unl_no_more_starts", 64'(st_cyc.size()), 64'd3);

        // Reset during the gap after frame 4, stray tx_done in IDLE, then rerun.
        clear_log();
        cfg_ifg = 32'd20; cfg_frames_per_burst = 32'd2; cfg_ibg = 32'd84; cfg_total_frames = 64'd100;
        ctrl_enable = 1'b1;
        wait_dones(4, 2000, "rst_four_dones");
        repeat (5) @(negedge clk);
        rst         = 1'b1;
        ctrl_enable = 1'b0;
        @(negedge clk);
        check("rst_tx_start", 64'(tx_start), 64'd0);
        check("rst_tx_seq", tx_seq, 64'd0);
        check("rst_frames_sent", frames_sent, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_run_done", 64'(run_done), 64'd0);
        check("rst_bursts_sent", 64'(bursts_sent), 64'd0);
        rst      = 1'b0;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        @(negedge clk);
        check("stray_done_ignored", frames_sent, 64'd0);
        clear_log();
        ctrl_enable = 1'b1;
        en_cyc      = cyc;
        wait_starts(1, 20, "rst_restart");
        if (st_cyc.size() > 0) begin
            check("rst_restart_seq", 64'(st_seq[0]), 64'd0);
            check("rst_restart_latency", 64'(st_cyc[0] - en_cyc), 64'd2);
        end
        ctrl_enable = 1'b0;
        wait_idle(300, "rst_final_idle");

        // Config change mid-run is ignored until the next start from IDLE.
        repeat (3) @(negedge clk);
        clear_log();
        cfg_ifg = 32'd20; cfg_frames_per_burst = 32'd8; cfg_ibg = 32'd84; cfg_total_frames = 64'd4;
        ctrl_limit  = 1'b1;
        ctrl_enable = 1'b1;
        wait_starts(1, 20, "cfg_first_start");
        cfg_ifg          = 32'd100;
        cfg_total_frames = 64'd1;
        wait_run_done(2000, "cfg_run_done");
        check("cfg_start_count", 64'(st_cyc.size()), 64'd4);
        check_spacing("cfg_old", 4, 21);
        ctrl_enable = 1'b0;
        repeat (3) @(negedge clk);
        clear_log();
        cfg_total_frames = 64'd2;
        ctrl_enable      = 1'b1;
        wait_run_done(2000, "cfg_new_run_done");
        check("cfg_new_start_count", 64'(st_cyc.size()), 64'd2);
        check_spacing("cfg_new", 2, 101);
        check("cfg_new_frames_sent", frames_sent, 64'd2);
        ctrl_enable = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
